// File: rtl/ex_mem_skid_buffer.sv
// EX->MEM pipeline register with valid/ready handshake, optional skid entry,
// flush, and a forwarding tap for the hazard/forward unit.
module ex_mem_skid_buffer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            MemRead_i,
  input  logic            MemtoReg_i,
  input  logic            MemWrite_i,
  input  logic            RegWrite_i,
  input  logic [XLEN-1:0] ALUResult_i,
  input  logic [XLEN-1:0] MemData_i,
  input  logic [REGW-1:0] rd_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            MemRead_o,
  output logic            MemtoReg_o,
  output logic            MemWrite_o,
  output logic            RegWrite_o,
  output logic [XLEN-1:0] ALUResult_o,
  output logic [XLEN-1:0] MemData_o,
  output logic [REGW-1:0] rd_o,
  output logic            fwd_en,
  output logic [REGW-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic [1:0]      occupancy
);

  typedef struct packed {
    logic            mem_read;
    logic            mem_to_reg;
    logic            mem_write;
    logic            reg_write;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mem_data;
    logic [REGW-1:0] rd;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_ready_q;
  logic   acc;
  logic   pop;

  // Bundle the incoming fields and derive the handshake events.
  always_comb begin
    in_entry = '{mem_read:   MemRead_i,
                 mem_to_reg: MemtoReg_i,
                 mem_write:  MemWrite_i,
                 reg_write:  RegWrite_i,
                 alu_result: ALUResult_i,
                 mem_data:   MemData_i,
                 rd:         rd_i};
    out_valid = (state_q != EMPTY);
    pop       = out_valid & out_ready;
    // Registered ready hides MEM backpressure from EX; without a skid entry
    // the head must drain in the same cycle, so ready follows out_ready.
    in_ready  = (SKID != 0) ? in_ready_q : (~out_valid | out_ready);
    acc       = in_valid & in_ready;
  end

  // Next-state and entry movement; flush overrides every other event.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = ONE;
          main_d  = in_entry;
        end
      end
      ONE: begin
        if (pop && acc) begin
          main_d = in_entry;
        end else if (pop) begin
          state_d = EMPTY;
        end else if (acc && (SKID != 0)) begin
          state_d = TWO;
          skid_d  = in_entry;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  // State, entry and registered-ready update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Head outputs; control bits are gated so a bubble never issues an operation.
  always_comb begin
    MemRead_o   = main_q.mem_read   & out_valid;
    MemtoReg_o  = main_q.mem_to_reg & out_valid;
    MemWrite_o  = main_q.mem_write  & out_valid;
    RegWrite_o  = main_q.reg_write  & out_valid;
    ALUResult_o = main_q.alu_result;
    MemData_o   = main_q.mem_data;
    rd_o        = main_q.rd;
    fwd_en      = out_valid & RegWrite_o & ~MemtoReg_o & (rd_o != '0);
    fwd_rd      = rd_o;
    fwd_data    = ALUResult_o;
    occupancy   = state_q;
  end

endmodule

// File: tb/tb_ex_mem_skid_buffer.sv
// Scoreboard bench for ex_mem_skid_buffer: one SKID=1 and one SKID=0 instance
// share the stimulus, each tracked by its own reference FIFO.
module tb_ex_mem_skid_buffer;

  typedef struct packed {
    logic        mr;
    logic        m2r;
    logic        mw;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] md;
    logic [4:0]  rd;
  } pay_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  pay_t pin = '0;

  logic        a_ir, a_ov, a_mr, a_m2r, a_mw, a_rw, a_fe;
  logic [31:0] a_alu, a_md, a_fd;
  logic [4:0]  a_rd, a_frd;
  logic [1:0]  a_occ;
  logic        b_ir, b_ov, b_mr, b_m2r, b_mw, b_rw, b_fe;
  logic [31:0] b_alu, b_md, b_fd;
  logic [4:0]  b_rd, b_frd;
  logic [1:0]  b_occ;

  pay_t sa[$];
  pay_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  ex_mem_skid_buffer #(.XLEN(32), .REGW(5), .SKID(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
    .MemRead_i(pin.mr), .MemtoReg_i(pin.m2r), .MemWrite_i(pin.mw), .RegWrite_i(pin.rw),
    .ALUResult_i(pin.alu), .MemData_i(pin.md), .rd_i(pin.rd),
    .out_valid(a_ov), .out_ready(out_ready),
    .MemRead_o(a_mr), .MemtoReg_o(a_m2r), .MemWrite_o(a_mw), .RegWrite_o(a_rw),
    .ALUResult_o(a_alu), .MemData_o(a_md), .rd_o(a_rd),
    .fwd_en(a_fe), .fwd_rd(a_frd), .fwd_data(a_fd), .occupancy(a_occ)
  );

  ex_mem_skid_buffer #(.XLEN(32), .REGW(5), .SKID(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
    .MemRead_i(pin.mr), .MemtoReg_i(pin.m2r), .MemWrite_i(pin.mw), .RegWrite_i(pin.rw),
    .ALUResult_i(pin.alu), .MemData_i(pin.md), .rd_i(pin.rd),
    .out_valid(b_ov), .out_ready(out_ready),
    .MemRead_o(b_mr), .MemtoReg_o(b_m2r), .MemWrite_o(b_mw), .RegWrite_o(b_rw),
    .ALUResult_o(b_alu), .MemData_o(b_md), .rd_o(b_rd),
    .fwd_en(b_fe), .fwd_rd(b_frd), .fwd_data(b_fd), .occupancy(b_occ)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic check_dut(input string p, input int sz, input pay_t h, input logic ir_exp,
                           input logic ir, input logic ov, input logic [3:0] ctrl,
                           input logic [31:0] alu, input logic [31:0] md, input logic [4:0] rd,
                           input logic fe, input logic [4:0] frd, input logic [31:0] fd,
                           input logic [1:0] occ);
    chk({p, "in_ready"}, 64'(ir), 64'(ir_exp));
    chk({p, "out_valid"}, 64'(ov), 64'(sz != 0));
    chk({p, "occupancy"}, 64'(occ), 64'(sz));
    if (sz != 0) begin
      chk({p, "ctrl"}, 64'(ctrl), 64'({h.mr, h.m2r, h.mw, h.rw}));
      chk({p, "alu"}, 64'(alu), 64'(h.alu));
      chk({p, "memdata"}, 64'(md), 64'(h.md));
      chk({p, "rd"}, 64'(rd), 64'(h.rd));
      chk({p, "fwd_en"}, 64'(fe), 64'(h.rw & ~h.m2r & (h.rd != 5'd0)));
      chk({p, "fwd_rd"}, 64'(frd), 64'(h.rd));
      chk({p, "fwd_data"}, 64'(fd), 64'(h.alu));
    end else begin
      chk({p, "ctrl_bubble"}, 64'(ctrl), 64'd0);
      chk({p, "fwd_en_bubble"}, 64'(fe), 64'd0);
    end
  endtask

  // One clock: check both DUTs against their models, advance the models at the edge.
  task automatic cyc();
    logic ira, irb, acca, accb, popa, popb;
    pay_t ha, hb;
    #1;
    ha = (sa.size() != 0) ? sa[0] : '0;
    hb = (sb.size() != 0) ? sb[0] : '0;
    ira = (sa.size() < 2);
    irb = (sb.size() == 0) | out_ready;
    check_dut("A.", sa.size(), ha, ira, a_ir, a_ov, {a_mr, a_m2r, a_mw, a_rw},
              a_alu, a_md, a_rd, a_fe, a_frd, a_fd, a_occ);
    check_dut("B.", sb.size(), hb, irb, b_ir, b_ov, {b_mr, b_m2r, b_mw, b_rw},
              b_alu, b_md, b_rd, b_fe, b_frd, b_fd, b_occ);
    acca = in_valid & ira;
    accb = in_valid & irb;
    popa = (sa.size() != 0) & out_ready;
    popb = (sb.size() != 0) & out_ready;
    @(posedge clk);
    if (rst || flush) begin
      sa.delete();
      sb.delete();
    end else begin
      if (popa) void'(sa.pop_front());
      if (acca) sa.push_back(pin);
      if (popb) void'(sb.pop_front());
      if (accb) sb.push_back(pin);
    end
    #1;
  endtask

  function automatic pay_t mk(input logic [31:0] alu);
    pay_t p;
    p = '0;
    p.alu = alu;
    p.md  = ~alu;
    p.rd  = alu[4:0];
    return p;
  endfunction

  initial begin
    // Reset held two edges with in_valid high.
    rst = 1'b1;
    in_valid = 1'b1;
    pin = mk(32'hdead);
    @(posedge clk);
    #1;
    cyc();
    chk("rst_alu", 64'(a_alu), 64'd0);
    chk("rst_md", 64'(a_md), 64'd0);
    chk("rst_rd", 64'(a_rd), 64'd0);
    chk("rst_occ", 64'(a_occ), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_release_ready", 64'(a_ir), 64'd1);

    // Stream 1,2,3 with MEM always ready.
    out_ready = 1'b1;
    for (int unsigned i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      pin = mk(32'(i));
      cyc();
      chk("stream_val", 64'(a_alu), 64'(i));
      chk("stream_occ", 64'(a_occ), 64'd1);
    end
    in_valid = 1'b0;
    cyc();

    // Backpressure: A then B fill main and skid.
    out_ready = 1'b0;
    in_valid = 1'b1;
    pin = mk(32'h10);
    cyc();
    pin = mk(32'h20);
    cyc();
    in_valid = 1'b0;
    chk("two_occ", 64'(a_occ), 64'd2);
    chk("two_ready", 64'(a_ir), 64'd0);
    out_ready = 1'b1;
    cyc();
    chk("drain_b", 64'(a_alu), 64'h20);
    cyc();
    cyc();

    // Flush while TWO with an incoming store C that must be dropped.
    out_ready = 1'b0;
    in_valid = 1'b1;
    pin = mk(32'h11);
    cyc();
    pin = mk(32'h12);
    cyc();
    flush = 1'b1;
    pin = mk(32'h30);
    pin.mw = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(a_ov), 64'd0);
    chk("flush_occ", 64'(a_occ), 64'd0);
    chk("flush_mw", 64'(a_mw), 64'd0);
    out_ready = 1'b1;
    cyc();
    cyc();

    // Forwarding tap: rd=0 never forwards, rd=5 does.
    in_valid = 1'b1;
    pin = mk(32'h77);
    pin.rw = 1'b1;
    pin.rd = 5'd0;
    cyc();
    chk("fwd_rd0", 64'(a_fe), 64'd0);
    pin.rd = 5'd5;
    cyc();
    chk("fwd_rd5_en", 64'(a_fe), 64'd1);
    chk("fwd_rd5_rd", 64'(a_frd), 64'd5);
    chk("fwd_rd5_data", 64'(a_fd), 64'h77);
    in_valid = 1'b0;
    cyc();

    // SKID=0: held head blocks ready; raising out_ready reopens it combinationally.
    out_ready = 1'b0;
    in_valid = 1'b1;
    pin = mk(32'h40);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("skid0_blocked", 64'(b_ir), 64'd0);
    cyc();
    out_ready = 1'b1;
    in_valid = 1'b1;
    pin = mk(32'h50);
    #1;
    chk("skid0_ready_same_cycle", 64'(b_ir), 64'd1);
    cyc();
    chk("skid0_replace", 64'(b_alu), 64'h50);
    in_valid = 1'b0;
    cyc();
    cyc();
    cyc();

    // Randomised traffic with occasional flush and mid-stream reset.
    for (int unsigned i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(24) == 0);
      rst       = ($urandom_range(79) == 0);
      pin.mr  = 1'($urandom);
      pin.m2r = 1'($urandom);
      pin.mw  = 1'($urandom);
      pin.rw  = 1'($urandom);
      pin.alu = $urandom;
      pin.md  = $urandom;
      pin.rd  = 5'($urandom);
      cyc();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
